// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: fetch_unit drives requests (master), memory answers (slave).
interface fetch_unit_if;
  logic        imem_req_valid_op;
  logic        imem_req_ready_ip;
  logic [31:0] imem_req_addr_op;
  logic        imem_resp_valid_ip;
  logic [31:0] imem_resp_data_ip;

  modport master (
    output imem_req_valid_op,
    output imem_req_addr_op,
    input  imem_req_ready_ip,
    input  imem_resp_valid_ip,
    input  imem_resp_data_ip
  );

  modport slave (
    input  imem_req_valid_op,
    input  imem_req_addr_op,
    output imem_req_ready_ip,
    output imem_resp_valid_ip,
    output imem_resp_data_ip
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order fetch buffer, IF/ID register.
// Define FETCH_BTFN_PREDICT_EN for backward-taken branch prediction with internal redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master imem,
  input  logic         stall_ip,
  input  logic         flush_ip,
  input  logic [31:0]  redirect_pc_ip,
  output logic [31:0]  pc_op,
  output logic [31:0]  pc4_op,
  output logic         instr_data_valid_op,
  output logic [31:0]  instr_data_op,
  output logic         prediction_op
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [31:0]      pc_q, pc_d, pc4_q, pc4_d, data_q, data_d;
  logic             valid_q, valid_d, pred_q, pred_d;

  logic             req_fire, resp, push, load, credit, predict, redirect;
  logic [31:0]      head_pc, head_data, pred_target, target;
  logic [CNT_W:0]   inflight;

  assign head_pc   = fifo_pc_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign load      = (!valid_q || !stall_ip) && (count_q != '0);
  assign resp      = imem.imem_resp_valid_ip;

`ifdef FETCH_BTFN_PREDICT_EN
  logic [31:0] bimm;
  assign bimm = {{19{head_data[31]}}, head_data[31], head_data[7],
                 head_data[30:25], head_data[11:8], 1'b0};
  // Only backward conditional branches are predicted taken; JAL is left alone.
  assign predict     = load && (head_data[6:0] == 7'b1100011) && head_data[31] && !flush_ip;
  assign pred_target = (head_pc + bimm) & ~32'h3;
`else
  assign predict     = 1'b0;
  assign pred_target = '0;
`endif

  assign redirect = flush_ip || predict;
  assign target   = flush_ip ? (redirect_pc_ip & ~32'h3) : pred_target;
  assign inflight = {1'b0, outst_q} + {1'b0, count_q};
  assign credit   = inflight < (CNT_W + 1)'(FIFO_DEPTH);

  assign imem.imem_req_valid_op = !reset && !redirect && credit;
  assign imem.imem_req_addr_op  = fetch_pc_q;
  assign req_fire = imem.imem_req_valid_op && imem.imem_req_ready_ip;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    data_d     = data_q;
    valid_d    = valid_q;
    pred_d     = pred_q;
    push       = 1'b0;
    if (redirect) begin
      // Everything still in flight belongs to the old path and is dropped on return.
      fetch_pc_d = target;
      resp_pc_d  = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - CNT_W'(resp);
      drop_d     = outst_q - CNT_W'(resp);
      if (flush_ip) begin
        valid_d = 1'b0;
        pred_d  = 1'b0;
      end else begin
        pc_d    = head_pc;
        pc4_d   = head_pc + 32'd4;
        data_d  = head_data;
        valid_d = 1'b1;
        pred_d  = 1'b1;
      end
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(resp);
      if (resp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      push = resp && (drop_q == '0);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (load) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        pc_d     = head_pc;
        pc4_d    = head_pc + 32'd4;
        data_d   = head_data;
        valid_d  = 1'b1;
        pred_d   = 1'b0;
      end else if (!stall_ip) begin
        valid_d = 1'b0;
        pred_d  = 1'b0;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(load);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      pc_q       <= RESET_PC;
      pc4_q      <= RESET_PC + 32'd4;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pred_q     <= pred_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
      fifo_data_q[wr_ptr_q] <= imem.imem_resp_data_ip;
    end
  end

  assign pc_op               = pc_q;
  assign pc4_op              = pc4_q;
  assign instr_data_op       = data_q;
  assign instr_data_valid_op = valid_q;
  assign prediction_op       = pred_q;

endmodule
